// File: rtl/arb_requester.sv
// arb_requester: job FIFO feeding a request/grant FSM that streams len+1 beats per job.
// Optional grant-wait timeout is compiled in when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LEN_W-1:0] push_len,
  input  logic             gnt,
  output logic             req,
  output logic             beat,
  output logic             done,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             tout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [LEN_W-1:0] bcnt_q;
  logic             req_q;
  logic             wr_en;
  logic             pop;
  logic             last;
  logic             tmo;

  // Push acceptance is judged against the registered count only.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wr_en = push && !full;
  assign ovf   = push && full;

  assign last = (bcnt_q == '0);
  assign beat = (state_q == XFER) && gnt;
  assign done = beat && last;
  assign pop  = done;
  assign req  = req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_len;
  end

  // Leaving GAP with work still queued raises req already in IDLE, so req drops for one cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (gnt) begin
            state_q <= XFER;
            bcnt_q  <= mem_q[rd_ptr_q];
          end else if (tmo) begin
            state_q <= GAP;
            req_q   <= 1'b0;
          end
        end
        XFER: begin
          if (beat) begin
            if (last) begin
              state_q <= GAP;
              req_q   <= 1'b0;
            end else begin
              bcnt_q <= bcnt_q - 1'b1;
            end
          end
        end
        GAP: begin
          state_q <= IDLE;
          req_q   <= !empty;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q;

  // tout fires in the TIMEOUT-th ungranted REQ cycle; the head job stays queued for retry.
  assign tmo  = (state_q == REQ) && !gnt && (wcnt_q == TW'(TIMEOUT - 1));
  assign tout = tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if ((state_q == REQ) && !gnt && !tmo) begin
      wcnt_q <= wcnt_q + 1'b1;
    end else begin
      wcnt_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign tmo            = 1'b0;
  assign tout           = 1'b0;
  assign unused_timeout = |TIMEOUT;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester; the timeout scenario adapts to ARB_REQ_TIMEOUT_EN.
module tb_arb_requester;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic [LEN_W-1:0] push_len;
  logic             gnt;
  logic             req;
  logic             beat;
  logic             done;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             tout;

  int checks   = 0;
  int failures = 0;
  int nd;
  int nb;
  int nt;
  int nlow;

  arb_requester #(.DEPTH(4), .LEN_W(LEN_W), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_len (push_len),
    .gnt      (gnt),
    .req      (req),
    .beat     (beat),
    .done     (done),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .tout     (tout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic r, input logic b, input logic d);
    #1;
    check_eq({tag, ".req"}, req, r);
    check_eq({tag, ".beat"}, beat, b);
    check_eq({tag, ".done"}, done, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push = 1'b0; push_len = '0; gnt = 1'b0;
    @(posedge clk); #1;
    check_eq("rst.req", req, 0);
    check_eq("rst.beat", beat, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.full", full, 0);
    check_eq("rst.empty", empty, 1);
    check_eq("rst.ovf", ovf, 0);
    check_eq("rst.tout", tout, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single job, len=2, gnt held high
    step; push = 1'b1; push_len = 4'd2; gnt = 1'b1;
    check_eq("s1.empty_pre", empty, 1);
    step; push = 1'b0; expect_out("s1.idle", 0, 0, 0);
    check_eq("s1.empty_cnt", empty, 0);
    step; expect_out("s1.req", 1, 0, 0);
    step; expect_out("s1.b1", 1, 1, 0);
    step; expect_out("s1.b2", 1, 1, 0);
    step; expect_out("s1.b3", 1, 1, 1);
    step; expect_out("s1.gap", 0, 0, 0);
    check_eq("s1.empty_post", empty, 1);
    step; expect_out("s1.idle2", 0, 0, 0);

    // stall: len=3, gnt low for two cycles mid-transfer
    step; push = 1'b1; push_len = 4'd3; gnt = 1'b1;
    step; push = 1'b0; expect_out("s2.idle", 0, 0, 0);
    step; expect_out("s2.req", 1, 0, 0);
    step; expect_out("s2.b1", 1, 1, 0);
    step; expect_out("s2.b2", 1, 1, 0);
    step; gnt = 1'b0; expect_out("s2.stall1", 1, 0, 0);
    step; expect_out("s2.stall2", 1, 0, 0);
    step; gnt = 1'b1; expect_out("s2.b3", 1, 1, 0);
    step; expect_out("s2.b4", 1, 1, 1);
    step; expect_out("s2.gap", 0, 0, 0);
    step; expect_out("s2.idle2", 0, 0, 0);

    // overflow: five pushes with gnt low, then drain and count jobs
    step; gnt = 1'b0; push = 1'b1; push_len = 4'd0; #1;
    check_eq("s3.ovf1", ovf, 0);
    step; push_len = 4'd1; #1;
    check_eq("s3.ovf2", ovf, 0);
    step; push_len = 4'd0; #1;
    check_eq("s3.ovf3", ovf, 0);
    step; push_len = 4'd1; #1;
    check_eq("s3.ovf4", ovf, 0);
    check_eq("s3.full4", full, 0);
    step; push_len = 4'd2; #1;
    check_eq("s3.full5", full, 1);
    check_eq("s3.ovf5", ovf, 1);
    step; push = 1'b0; #1;
    check_eq("s3.full_hold", full, 1);
    check_eq("s3.ovf_clr", ovf, 0);
    gnt = 1'b1; nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      step; #1;
      if (done) nd++;
      if (beat) nb++;
    end
    check_eq("s3.jobs", nd, 4);
    check_eq("s3.beats", nb, 6);
    check_eq("s3.empty", empty, 1);

    // back-to-back len=0 jobs
    step; push = 1'b1; push_len = 4'd0; gnt = 1'b1;
    step; push = 1'b1; push_len = 4'd0; expect_out("s4.idle", 0, 0, 0);
    step; push = 1'b0; expect_out("s4.req1", 1, 0, 0);
    step; expect_out("s4.beat1", 1, 1, 1);
    step; expect_out("s4.gap", 0, 0, 0);
    check_eq("s4.empty_gap", empty, 0);
    step; expect_out("s4.idle_req", 1, 0, 0);
    step; expect_out("s4.req2", 1, 0, 0);
    step; expect_out("s4.beat2", 1, 1, 1);
    step; expect_out("s4.gap2", 0, 0, 0);
    check_eq("s4.empty_end", empty, 1);
    step; expect_out("s4.idle_end", 0, 0, 0);

    // async reset between edges in the middle of a transfer
    step; push = 1'b1; push_len = 4'd3; gnt = 1'b1;
    step; push = 1'b1; push_len = 4'd2; expect_out("s5.idle", 0, 0, 0);
    step; push = 1'b0; expect_out("s5.req", 1, 0, 0);
    step; expect_out("s5.b1", 1, 1, 0);
    step; expect_out("s5.b2", 1, 1, 0);
    #1; rst = 1'b1; #1;
    check_eq("s5.req_async", req, 0);
    check_eq("s5.beat_async", beat, 0);
    check_eq("s5.empty_async", empty, 1);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      step; #1;
      if (done) nd++;
    end
    step; rst = 1'b0; #1;
    check_eq("s5.req_rel", req, 0);
    for (int i = 0; i < 4; i++) begin
      step; #1;
      if (done || req) nd++;
    end
    check_eq("s5.no_done", nd, 0);
    check_eq("s5.empty_end", empty, 1);

    // grant starvation: timeout retry when enabled, indefinite wait otherwise
    step; push = 1'b1; push_len = 4'd1; gnt = 1'b0;
    step; push = 1'b0; expect_out("s6.idle", 0, 0, 0);
`ifdef ARB_REQ_TIMEOUT_EN
    nt = 0;
    for (int i = 1; i <= 15; i++) begin
      step; #1;
      if (!req) nt++;
      check_eq($sformatf("s6.tout%0d", i), tout, (i == 15) ? 1 : 0);
    end
    check_eq("s6.req_wait", nt, 0);
    step; #1;
    check_eq("s6.gap_req", req, 0);
    check_eq("s6.gap_tout", tout, 0);
    check_eq("s6.gap_empty", empty, 0);
    step; #1;
    check_eq("s6.retry_req", req, 1);
`else
    nt = 0; nlow = 0;
    for (int i = 0; i < 20; i++) begin
      step; #1;
      if (tout) nt++;
      if (!req) nlow++;
    end
    check_eq("s6.tout_none", nt, 0);
    check_eq("s6.req_wait", nlow, 0);
`endif
    step; gnt = 1'b1; expect_out("s6.req", 1, 0, 0);
    step; expect_out("s6.b1", 1, 1, 0);
    step; expect_out("s6.b2", 1, 1, 1);
    step; expect_out("s6.gap_end", 0, 0, 0);
    check_eq("s6.empty_end", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
